// File: rtl/booth_r4_mul.sv
// Sequential radix-4 (modified Booth) multiplier with run-time signed/unsigned mode.
// Handshake: start (sampled in IDLE) -> busy while iterating -> one-cycle done pulse.
// Optional macro BOOTH_EARLY_TERM_EN: stop iterating once all remaining Booth digits are zero.
module booth_r4_mul #(
   parameter  int unsigned WIDTH = 16,
   localparam int unsigned PW    = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] multiplicand_in,
   input  logic [WIDTH-1:0] multiplicator_in,
   output logic             busy,
   output logic             done,
   output logic [PW-1:0]    multiplication
);

   // Two guard bits make full-range unsigned operands exact under signed Booth recoding.
   localparam int unsigned IW = WIDTH + 2;
   localparam int unsigned N  = IW / 2;
   localparam int unsigned CW = $clog2(N);
   localparam int unsigned SW = CW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [IW-1:0]   r_a;
   logic [IW-1:0]   r_b;       // multiplier, arithmetically shifted right by 2 each digit
   logic            r_prev;    // bit below the current triplet (B[2i-1])
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_acc;
   logic            r_busy;
   logic            r_done;
   logic [PW-1:0]   r_mult;

   logic [2:0]      w_trip;
   logic [IW:0]     w_mag;
   logic            w_neg;
   logic [IW:0]     w_pp;
   logic [PW-1:0]   w_pp_ext;
   logic [SW-1:0]   w_sh;
   logic [PW-1:0]   w_acc_nxt;
   logic            w_last;
   logic [IW-1:0]   w_a_ext;
   logic [IW-1:0]   w_b_ext;

   assign busy           = r_busy;
   assign done           = r_done;
   assign multiplication = r_mult;

   assign w_a_ext = is_signed ? {{2{multiplicand_in[WIDTH-1]}}, multiplicand_in}
                              : {2'b00, multiplicand_in};
   assign w_b_ext = is_signed ? {{2{multiplicator_in[WIDTH-1]}}, multiplicator_in}
                              : {2'b00, multiplicator_in};

   assign w_trip = {r_b[1], r_b[0], r_prev};

   // Booth digit decode: magnitude (A or 2A) and negate flag.
   always_comb begin
      w_mag = '0;
      w_neg = 1'b0;
      case (w_trip)
         3'b001, 3'b010: w_mag = {r_a[IW-1], r_a};
         3'b011:         w_mag = {r_a, 1'b0};
         3'b100: begin
            w_mag = {r_a, 1'b0};
            w_neg = 1'b1;
         end
         3'b101, 3'b110: begin
            w_mag = {r_a[IW-1], r_a};
            w_neg = 1'b1;
         end
         default: begin
            w_mag = '0;
            w_neg = 1'b0;
         end
      endcase
   end

   // Negation as invert here plus carry-in at the digit's bit offset below.
   assign w_pp      = w_neg ? ~w_mag : w_mag;
   assign w_pp_ext  = {{(PW-IW-1){w_pp[IW]}}, w_pp};
   assign w_sh      = {r_cnt, 1'b0};
   assign w_acc_nxt = r_acc + (w_pp_ext << w_sh) + (PW'(w_neg) << w_sh);

`ifdef BOOTH_EARLY_TERM_EN
   // Remaining bits all equal means every later digit recodes to zero.
   assign w_last = (r_cnt == CW'(N - 1)) || (r_b[IW-1:1] == '0) || (r_b[IW-1:1] == '1);
`else
   assign w_last = (r_cnt == CW'(N - 1));
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_CALC;
         S_CALC:  if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture and one Booth digit accumulated per CALC cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_prev <= 1'b0;
         r_cnt  <= '0;
         r_acc  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a    <= w_a_ext;
                  r_b    <= w_b_ext;
                  r_prev <= 1'b0;
                  r_cnt  <= '0;
                  r_acc  <= '0;
               end
            end
            S_CALC: begin
               r_acc  <= w_acc_nxt;
               r_b    <= {{2{r_b[IW-1]}}, r_b[IW-1:2]};
               r_prev <= r_b[1];
               r_cnt  <= r_cnt + CW'(1);
            end
            default: begin
               r_acc <= r_acc;
            end
         endcase
      end
   end

   // Registered handshake outputs; product updates only on the DONE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_mult <= '0;
      end else begin
         r_busy <= (r_state == S_CALC);
         r_done <= (r_state == S_DONE);
         if (r_state == S_DONE) r_mult <= r_acc;
      end
   end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul (WIDTH=16): directed table, corner sequences, random.
module tb_booth_r4_mul;

   localparam int unsigned W = 16;
   localparam int unsigned P = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         is_signed = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [P-1:0] mult;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   booth_r4_mul #(.WIDTH(W)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .is_signed        (is_signed),
      .multiplicand_in  (a),
      .multiplicator_in (b),
      .busy             (busy),
      .done             (done),
      .multiplication   (mult)
   );

   typedef struct {
      bit          sgn;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Exact product from plain integer arithmetic.
   function automatic logic [31:0] model_mul(input bit sgn, input logic [15:0] x, input logic [15:0] y);
      longint xa, ya;
      if (sgn) begin
         xa = longint'($signed(x));
         ya = longint'($signed(y));
      end else begin
         xa = longint'({48'd0, x});
         ya = longint'({48'd0, y});
      end
      return 32'(xa * ya);
   endfunction

   // Cycles from start-sampling edge to done: digits processed + 1.
   function automatic int model_lat(input bit sgn, input logic [15:0] y);
`ifdef BOOTH_EARLY_TERM_EN
      logic [17:0] be;
      bit all0, all1;
      be = sgn ? {{2{y[15]}}, y} : {2'b00, y};
      for (int i = 0; i < 9; i++) begin
         all0 = 1'b1;
         all1 = 1'b1;
         for (int j = 2*i + 1; j < 18; j++) begin
            if (be[j]) all0 = 1'b0;
            else       all1 = 1'b0;
         end
         if (all0 || all1) return i + 2;
      end
      return 10;
`else
      if (sgn && y[0]) return 10;
      return 10;
`endif
   endfunction

   // Issue one multiply (called just after a rising edge) and wait for done.
   task automatic do_mul(input bit sgn, input logic [15:0] av, input logic [15:0] bv,
                         output logic [31:0] prod, output int lat, output int bcnt, output bit held_ok);
      logic [31:0] prev;
      prev      = mult;
      start     = 1'b1;
      is_signed = sgn;
      a         = av;
      b         = bv;
      @(posedge clk); #1;
      start     = 1'b0;
      a         = 16'($urandom);
      b         = 16'($urandom);
      is_signed = 1'($urandom);
      lat       = 0;
      bcnt      = 0;
      held_ok   = 1'b1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         if (mult !== prev) held_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      prod = mult;
   endtask

   task automatic run_check(input string name, input bit sgn, input logic [15:0] av,
                            input logic [15:0] bv, input logic [31:0] exp);
      logic [31:0] prod;
      int lat, bcnt, el;
      bit held_ok;
      el = model_lat(sgn, bv);
      do_mul(sgn, av, bv, prod, lat, bcnt, held_ok);
      chk($sformatf("%s product", name), prod, exp);
      chk($sformatf("%s latency", name), 32'(lat), 32'(el));
      chk($sformatf("%s busy_cycles", name), 32'(bcnt), 32'(el - 1));
      chk($sformatf("%s held", name), 32'(held_ok), 32'd1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] prod, e1;
      int lat, bcnt, dcnt, n;
      bit held_ok, sg;
      logic [15:0] ra, rb;

      vecs[0] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
      vecs[1] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000};
      vecs[2] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000};
      vecs[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      vecs[4] = '{1'b0, 16'h8000, 16'h0002, 32'h0001_0000};
      vecs[5] = '{1'b1, 16'h0005, 16'h0003, 32'h0000_000F};
      vecs[6] = '{1'b0, 16'h0000, 16'h1234, 32'h0000_0000};
      vecs[7] = '{1'b1, 16'h0003, 16'hFFFE, 32'hFFFF_FFFA};
      vecs[8] = '{1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000};
      vecs[9] = '{1'b0, 16'h0001, 16'h8000, 32'h0000_8000};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset mult", mult, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 10; i++)
         run_check($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Start re-pulsed mid-multiply must be ignored.
      e1        = model_mul(1'b1, 16'h1111, 16'h4321);
      start     = 1'b1;
      is_signed = 1'b1;
      a         = 16'h1111;
      b         = 16'h4321;
      @(posedge clk); #1;
      start = 1'b0;
      n     = 0;
      while (done !== 1'b1 && n < 40) begin
         if (n == 3) begin
            start = 1'b1;
            a     = 16'h2222;
            b     = 16'h0101;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("repulse product", mult, e1);
      chk("repulse latency", 32'(n), 32'(model_lat(1'b1, 16'h4321)));
      dcnt = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done === 1'b1) dcnt++;
      end
      chk("repulse extra_done", 32'(dcnt), 32'd0);
      chk("repulse held", mult, e1);
      run_check("after_repulse", 1'b0, 16'h00FF, 16'h0101, model_mul(1'b0, 16'h00FF, 16'h0101));

      // Back-to-back: second start raised in the done cycle of the first.
      do_mul(1'b1, 16'h1234, 16'h5678, prod, lat, bcnt, held_ok);
      chk("b2b first", prod, model_mul(1'b1, 16'h1234, 16'h5678));
      do_mul(1'b0, 16'hABCD, 16'hC001, prod, lat, bcnt, held_ok);
      chk("b2b second", prod, model_mul(1'b0, 16'hABCD, 16'hC001));
      chk("b2b done_gap", 32'(lat + 1), 32'(model_lat(1'b0, 16'hC001) + 1));

      // Asynchronous reset in the 5th CALC cycle.
      start     = 1'b1;
      is_signed = 1'b1;
      a         = 16'h1234;
      b         = 16'h4321;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst mult", mult, 32'd0);
      dcnt = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done === 1'b1) dcnt++;
      end
      rst = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) dcnt++;
      end
      chk("midrst no_done", 32'(dcnt), 32'd0);
      run_check("after_rst", 1'b1, 16'h0003, 16'hFFFE, 32'hFFFF_FFFA);

      // Randomized against the arithmetic model; some short multipliers for early exit.
      for (int i = 0; i < 40; i++) begin
         sg = 1'($urandom);
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 4 == 0) rb = 16'($urandom_range(0, 15));
         if (i % 4 == 1) rb = 16'hFFFF - 16'($urandom_range(0, 15));
         run_check($sformatf("rnd%0d", i), sg, ra, rb, model_mul(sg, ra, rb));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/booth_r4_mul.md
Name: booth_r4_mul

Overview:
- Parametrised sequential radix-4 (modified Booth) multiplier. Successor to the 16-bit radix-2 Booth datapath.
- Retires two multiplier bits per clock, which halves the iteration count.
- Supports a run-time signed or unsigned mode.
- Uses a start/busy/done handshake, so a controller can issue back-to-back multiplies.

Parameters:
- WIDTH, 16, operand width in bits; must be even and at least 4.
- PW, 2*WIDTH, product width (derived, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- multiplicand_in  in  WIDTH  operand A; captured with start.
- multiplicator_in  in  WIDTH  operand B; captured with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when the product is valid.
- multiplication  out  PW  product; held until the next accepted start.

Behaviour:
- Reset (rst low, asynchronous, any state): state=IDLE, busy=0, done=0, multiplication=0, all internal registers cleared. A multiply in flight is abandoned and no done is issued. Operation resumes on the first clk edge after rst goes high.
- Internal width IW=WIDTH+2. Operands are extended to IW bits: sign-extended if is_signed=1, zero-extended if is_signed=0. This makes unsigned full-range inputs exact. Iteration count N=IW/2 (9 for WIDTH=16).
- States:
  - IDLE: on start=1, latch A, B, is_signed; clear accumulator and iteration counter; move to CALC. busy rises on the next cycle.
  - CALC: one Booth digit per cycle. Triplet {B[2i+1], B[2i], B[2i-1]} with B[-1]=0. Digit encoding: 000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A.
    - Partial product is formed at IW+1 bits: 2A via shift, negation via invert plus carry-in.
    - It is added into a PW-bit accumulator at bit offset 2i, sign-extended to PW. Arithmetic is modulo 2^PW.
    - After digit N-1, move to DONE.
  - DONE: for one cycle, multiplication is loaded from the accumulator, done=1 and busy=0. Then return to IDLE.
- Latency, start-sampling edge to done: N+1 cycles (10 for WIDTH=16). done is asserted in the cycle after the last CALC cycle.
- Throughput: start may be asserted in the cycle done is high. It is sampled on the next edge in IDLE, giving a minimum issue interval of N+2 cycles.
- start while busy or DONE is ignored. Operand changes after capture have no effect.
- is_signed=1 result is the exact two's-complement product. Corner case: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), fits in PW bits.
- multiplication changes only in DONE. It is stable for all other cycles.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined:
  - After each CALC iteration i, if B[IW-1:2i+1] are all equal (all 0s or all 1s, including bit 2i+1 itself), every remaining digit is 0. The FSM goes straight to DONE on the next edge.
  - The product is identical to full iteration. Latency becomes k+1 cycles, where k is the number of digits actually processed (at least 1).
- Not defined: fixed N iterations and fixed latency. No comparison logic is synthesised.

Test Plan:
- Signed, A=0xFFFF, B=0xFFFF (-1 * -1) -> multiplication=0x00000001, done exactly 10 cycles after the start edge, busy high for 9 cycles.
- Signed, A=0x8000, B=0x8000 -> 0x40000000. Signed A=0x7FFF, B=0x8000 -> 0xC0008000.
- Unsigned, A=0xFFFF, B=0xFFFF -> 0xFFFE0001. Unsigned A=0x8000, B=0x0002 -> 0x00010000.
- start pulsed again 3 cycles into a multiply with different operands -> ignored; first product returned; next start accepted only after done. Back-to-back start in the done cycle -> second done 11 cycles after the first.
- rst driven low in the 5th CALC cycle -> busy, done, multiplication go to 0 immediately (asynchronous). No done pulse. A fresh multiply after release (signed 0x0003*0xFFFE) -> 0xFFFFFFFA.
- With BOOTH_EARLY_TERM_EN, signed B=0x0003, A=0x0005 -> 0x0000000F with done 3 cycles after start. B=0xFFFF -> done 2 cycles after start. Without the macro both take 10 cycles with the same product.
